// File: rtl/ads1115_pkg.sv
// Shared constants and FSM encoding for the ADS1115-compatible I2C target.
package ads1115_pkg;

  localparam logic [1:0] PTR_CONV      = 2'd0;
  localparam logic [1:0] PTR_CONFIG    = 2'd1;
  localparam logic [1:0] PTR_LO_THRESH = 2'd2;
  localparam logic [1:0] PTR_HI_THRESH = 2'd3;

  localparam logic [15:0] CONFIG_RESET    = 16'h8583;
  localparam logic [15:0] LO_THRESH_RESET = 16'h8000;
  localparam logic [15:0] HI_THRESH_RESET = 16'h7FFF;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK
  } state_t;

endpackage

// File: rtl/ads1115_target_i2c_line_sync.sv
// Synchronizes raw SCL/SDA into clk and flags SCL edges plus START/STOP.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_q;
  logic       sda_q;
  logic       scl;

  // Bus idles high, so reset the chains to 1 to avoid spurious edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_raw};
      sda_sync <= {sda_sync[0], sda_raw};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  assign scl      = scl_sync[1];
  assign sda      = sda_sync[1];
  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  assign start    = scl & scl_q & sda_q & ~sda;
  assign stop     = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/ads1115_target.sv
// ADS1115-style I2C target: pointer/config/conversion registers and a
// sample-request handshake that stands in for the analog front end.
module ads1115_target
  import ads1115_pkg::*;
#(
  parameter logic [6:0]  ADDRESS     = 7'h48,
  parameter int unsigned CONV_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  output logic        sample_req_o,
  output logic [1:0]  sample_channel_o,
  input  logic [15:0] sample_data_i,
  input  logic        sample_valid_i,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(CONV_CYCLES + 1);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_line_sync u_sync (
    .clk      (clk_i),
    .rst      (rst_i),
    .scl_raw  (scl_i),
    .sda_raw  (sda_i),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_t      state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shift, shift_n;
  logic [6:0]  tx, tx_n;
  logic        sda_oe, sda_oe_n;
  logic [1:0]  byte_cnt, byte_cnt_n;
  logic [7:0]  msb_stage, msb_stage_n;
  logic [7:0]  snap_lo, snap_lo_n;
  logic        lsb_next, lsb_next_n;
  logic [1:0]  pointer, pointer_n;
  logic        commit;
  logic [15:0] commit_data;

  logic [14:0]   cfg;
  logic [15:0]   conv_reg;
  logic [15:0]   sample_buf;
  logic          sample_got;
  logic [CW-1:0] cyc_cnt;
  logic          conv_elapsed;
  logic [15:0]   rd_value;

  always_comb begin
    rd_value = conv_reg;
    case (pointer)
      PTR_CONV:      rd_value = conv_reg;
      PTR_CONFIG:    rd_value = {~busy_o, cfg};
      PTR_LO_THRESH: rd_value = LO_THRESH_RESET;
      default:       rd_value = HI_THRESH_RESET;
    endcase
  end

  assign commit_data = {msb_stage, shift};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      tx        <= '0;
      sda_oe    <= 1'b0;
      byte_cnt  <= '0;
      msb_stage <= '0;
      snap_lo   <= '0;
      lsb_next  <= 1'b0;
      pointer   <= PTR_CONV;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      tx        <= tx_n;
      sda_oe    <= sda_oe_n;
      byte_cnt  <= byte_cnt_n;
      msb_stage <= msb_stage_n;
      snap_lo   <= snap_lo_n;
      lsb_next  <= lsb_next_n;
      pointer   <= pointer_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    tx_n        = tx;
    sda_oe_n    = sda_oe;
    byte_cnt_n  = byte_cnt;
    msb_stage_n = msb_stage;
    snap_lo_n   = snap_lo;
    lsb_next_n  = lsb_next;
    pointer_n   = pointer;
    commit      = 1'b0;
    if (stop) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
    end else if (start) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (shift[7:1] == ADDRESS) begin
              state_n  = ADDR_ACK;
              sda_oe_n = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = '0;
            if (shift[0]) begin
              state_n    = RD_BYTE;
              tx_n       = rd_value[14:8];
              snap_lo_n  = rd_value[7:0];
              sda_oe_n   = ~rd_value[15];
              lsb_next_n = 1'b1;
            end else begin
              state_n    = WR_BYTE;
              sda_oe_n   = 1'b0;
              byte_cnt_n = '0;
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            state_n  = WR_ACK;
            sda_oe_n = 1'b1;
            case (byte_cnt)
              2'd0:    pointer_n   = shift[1:0];
              2'd1:    msb_stage_n = shift;
              2'd2:    commit      = 1'b1;
              default: ;
            endcase
            if (byte_cnt != 2'd3) byte_cnt_n = byte_cnt + 2'd1;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_n   = WR_BYTE;
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
          end
        end
        RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_n  = RD_ACK;
              sda_oe_n = 1'b0;
            end else begin
              sda_oe_n = ~tx[6];
              tx_n     = {tx[5:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && sda) begin
            state_n = IDLE;
          end else if (scl_fall) begin
            state_n   = RD_BYTE;
            bit_cnt_n = '0;
            // LSB comes from the pair snapshot; a new pair re-samples the register.
            if (lsb_next) begin
              tx_n       = snap_lo[6:0];
              sda_oe_n   = ~snap_lo[7];
              lsb_next_n = 1'b0;
            end else begin
              tx_n       = rd_value[14:8];
              snap_lo_n  = rd_value[7:0];
              sda_oe_n   = ~rd_value[15];
              lsb_next_n = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe_o     = sda_oe;
  assign conv_elapsed = cyc_cnt >= CW'(CONV_CYCLES - 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg              <= CONFIG_RESET[14:0];
      conv_reg         <= '0;
      sample_buf       <= '0;
      sample_got       <= 1'b0;
      cyc_cnt          <= '0;
      busy_o           <= 1'b0;
      sample_req_o     <= 1'b0;
      sample_channel_o <= '0;
    end else begin
      if (busy_o) begin
        if (!conv_elapsed) cyc_cnt <= cyc_cnt + 1'b1;
        if (sample_req_o && sample_valid_i) begin
          sample_req_o <= 1'b0;
          sample_got   <= 1'b1;
          sample_buf   <= sample_data_i;
        end
        if (conv_elapsed && sample_got) begin
          conv_reg <= sample_buf;
          busy_o   <= 1'b0;
        end
      end
      if (commit && pointer == PTR_CONFIG) begin
        cfg <= commit_data[14:0];
        if (commit_data[15] && !busy_o) begin
          busy_o           <= 1'b1;
          sample_req_o     <= 1'b1;
          sample_got       <= 1'b0;
          cyc_cnt          <= '0;
          sample_channel_o <= commit_data[13:12];
        end
      end
    end
  end

endmodule
